xnor_correlator: RTL

Parametrised serial bit-pattern correlator, the sequential successor of the single-bit XNOR gate. Serial bits shift into a WIDTH-bit window. The window is compared bitwise (XNOR) against a loadable reference pattern, and the number of agreeing bits is counted. A match is flagged when that count reaches a threshold. It is used for sync-word / preamble detection ahead of framing logic.

---
 rtl/xnor_correlator.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/xnor_correlator.sv
// xnor_correlator: serial bit-pattern correlator for sync-word/preamble detection.
//
// Serial bits shift into a WIDTH-bit window (oldest bit at window[WIDTH-1],
// so the reference pattern is sent MSB first). The window is XNOR-compared
// against a loadable pattern. The number of agreeing bits is registered as
// 'score' one cycle after each accepted bit, once the window is full.
//
// Optional build macro XNOR_CORR_MASK_EN adds a mask register. It is loaded
// from mask_data on pat_load and resets to all ones. Masked-off (0) bit
// positions always count as agreeing.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           synchronous clear of window, fill, pipeline, match counter
//   pat_load        load pat_data (and mask_data when enabled)
//   pat_data        reference pattern
//   mask_data       compare mask (XNOR_CORR_MASK_EN only)
//   bit_in          serial data bit, qualified by bit_valid
//   armed           window holds WIDTH valid bits since reset/clear
//   score           agreeing-bit count for the last scored window
//   score_valid     one-cycle pulse, score/match valid
//   match           score >= THRESH, qualified by score_valid
//   match_count     saturating count of match pulses

module xnor_corr_lane (
    input  logic w,
    input  logic p,
    input  logic m,
    output logic agree
);
    // A masked-off position is a don't-care and always agrees.
    assign agree = ~(w ^ p) | ~m;
endmodule

module xnor_correlator #(
    parameter int               WIDTH         = 8,
    parameter int               THRESH        = 8,
    parameter int               CNT_W         = 8,
    parameter logic [WIDTH-1:0] RESET_PATTERN = '0,
    localparam int              SW            = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             pat_load,
    input  logic [WIDTH-1:0] pat_data,
`ifdef XNOR_CORR_MASK_EN
    input  logic [WIDTH-1:0] mask_data,
`endif
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             armed,
    output logic [SW-1:0]    score,
    output logic             score_valid,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);
    localparam int STAGES = 2;

    logic [WIDTH-1:0]  window_q;
    logic [WIDTH-1:0]  pattern_q;
    logic [WIDTH-1:0]  mask_w;
    logic [WIDTH-1:0]  agree;
    logic [SW-1:0]     fill_q;
    logic [SW-1:0]     fill_nxt;
    logic [SW-1:0]     pop;
    logic              accept;
    logic              full_nxt;
    logic              hit;
    logic              fire;
    // [1]: a bit was accepted into a full window (score due next edge)
    // [2]: score/match registered this cycle
    logic [STAGES:1]   vld_pipe;

    assign accept   = bit_valid & ~clear;
    assign full_nxt = (fill_nxt == SW'(WIDTH));

    always_comb begin
        fill_nxt = fill_q;
        if (clear)
            fill_nxt = '0;
        else if (bit_valid && fill_q != SW'(WIDTH))
            fill_nxt = fill_q + 1'b1;
    end

`ifdef XNOR_CORR_MASK_EN
    logic [WIDTH-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            mask_q <= '1;
        else if (pat_load)
            mask_q <= mask_data;
    end

    assign mask_w = mask_q;
`else
    assign mask_w = '1;
`endif

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        xnor_corr_lane u_lane (
            .w     (window_q[g]),
            .p     (pattern_q[g]),
            .m     (mask_w[g]),
            .agree (agree[g])
        );
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < WIDTH; i++)
            pop = pop + SW'(agree[i]);
    end

    assign hit  = (pop >= SW'(THRESH));
    // A clear in the scoring cycle kills the in-flight result.
    assign fire = vld_pipe[1] & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q    <= '0;
            fill_q      <= '0;
            armed       <= 1'b0;
            pattern_q   <= RESET_PATTERN;
            vld_pipe    <= '0;
            score       <= '0;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            if (clear)
                window_q <= '0;
            else if (bit_valid)
                window_q <= {window_q[WIDTH-2:0], bit_in};

            fill_q <= fill_nxt;
            armed  <= full_nxt;

            if (pat_load)
                pattern_q <= pat_data;

            vld_pipe[1] <= accept & full_nxt;
            vld_pipe[2] <= fire;

            // Score holds its last value between pulses.
            if (fire)
                score <= pop;
            match <= fire & hit;

            if (clear)
                match_count <= '0;
            else if (fire && hit && match_count != '1)
                match_count <= match_count + 1'b1;
        end
    end

    assign score_valid = vld_pipe[2];

endmodule
